proc_io_link: RTL and testbench
===============================

# proc_io_link

Device-side endpoint of the processor's external I/O interface. It sits between the processor and the off-chip peripherals (keyboard, Ethernet, PPU, accelerator). Outbound, it captures the processor's one-cycle command strobes (`snd`, `sac`, `uad`, `ppu_send`) with `interface_data` into a command FIFO that peripherals drain through a valid/ready handshake. Inbound, it buffers keyboard and Ethernet events, then presents them one at a time as `interrupt_key` / `interrupt_eth` with stable `interrupt_source_data` until the processor acknowledges.

## Interface
- `CMD_DEPTH`, 8: command FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; one clock domain, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `snd`, `sac`, `uad`, `ppu_send`  in  1 each  processor command strobes, one cycle wide.
- `interface_data`  in  32  command payload, valid in the same cycle as a strobe.
- `cmd_valid`  out  1  FIFO head is valid.
- `cmd_ready`  in  1  peripheral accepts the head entry.
- `cmd_op`  out  2  head opcode (`cmd_op_t`).
- `cmd_data`  out  32  head payload.
- `cmd_overflow`  out  1  sticky: a command was dropped because the FIFO was full.
- `cmd_collision`  out  1  sticky: more than one strobe was asserted in the same cycle.
- `key_evt`  in  1  keyboard event pulse.
- `key_code`  in  32  keyboard payload.
- `eth_evt`  in  1  Ethernet event pulse.
- `eth_data`  in  32  Ethernet payload.
- `int_ack`  in  1  pulse from the processor's RTI/RSI path; ends the current interrupt.
- `interrupt_key`, `interrupt_eth`  out  1 each  level interrupt to the processor.
- `interrupt_source_data`  out  32  payload of the presented event.
- `evt_dropped`  out  1  sticky: an event arrived while its holding register was full.

## Operation
- Reset: FIFO empty, FSM in IDLE, both holding registers empty. Every output is 0, including the stickies. The stickies clear only on `rst`.
- Command capture: a strobe pushes `{op, interface_data}`.
  - If several strobes are asserted together, one entry is pushed using priority `ppu_send` > `snd` > `sac` > `uad`, and `cmd_collision` is set.
- Full FIFO: the push is dropped and `cmd_overflow` is set, unless a pop happens in the same cycle; in that case the push is accepted.
- Pop: occurs when `cmd_valid && cmd_ready`. `cmd_ready` while empty has no effect.
- Occupancy counter: `$clog2(CMD_DEPTH)+1` bits. Pointers wrap modulo `CMD_DEPTH`.
- Holding registers: each source has a pending flag and a 32-bit data register.
  - An event on an empty holder captures the payload.
  - An event on a full holder is discarded (data not overwritten) and `evt_dropped` is set.
  - An event arriving in the same cycle its holder is cleared by `int_ack` is captured.
- Interrupt FSM states: IDLE, KEY, ETH, GAP.
  - IDLE → KEY when the key holder is pending; otherwise IDLE → ETH when the Ethernet holder is pending. Key has priority.
  - In KEY: `interrupt_key` = 1 and `interrupt_source_data` = the key holder's data. ETH is symmetric.
  - KEY/ETH → GAP on `int_ack`; the served holder is cleared.
  - GAP → IDLE unconditionally. Interrupt outputs are 0 in GAP and IDLE, which guarantees at least 2 low cycles between interrupts.
  - `int_ack` in IDLE or GAP is ignored.
- `interrupt_source_data` is 0 whenever no interrupt is asserted.

## Timing
- Command latency: strobe sampled at edge E → `cmd_valid` = 1 after E. The FIFO is first-word fall-through, and all outputs are registered or driven straight from registers.
- Event latency: event sampled at edge E → holder set at E → FSM enters KEY/ETH at E+1 → interrupt high after E+1.
- Interrupt level and data are held stable until `int_ack`. They drop after the acknowledging edge.
- `rst` mid-operation: all state returns to reset values on the next edge. In-flight commands and pending events are lost.

## Structure
- Package `proc_io_pkg`:
  - `cmd_op_t` enum: `CMD_SND`=0, `CMD_SAC`=1, `CMD_UAD`=2, `CMD_PPU`=3.
  - `irq_state_t` enum: IDLE, KEY, ETH, GAP.
- Sub-module `io_cmd_fifo`: a parameterized 34-bit-wide synchronous FWFT FIFO with a full/empty count.
- The top level holds the strobe encoder, the holding registers and the FSM.

## Test plan
- Single command: `snd` with data 0xDEADBEEF → `cmd_valid` next cycle, `cmd_op`=0, `cmd_data`=0xDEADBEEF; popped with `cmd_ready` → `cmd_valid`=0.
- Overflow: 9 `sac` strobes with `cmd_ready`=0 and depth 8 → 8 entries in order, `cmd_overflow`=1. Then a simultaneous push+pop while full → count stays 8 and the new entry appears last.
- Collision: `ppu_send` and `uad` asserted in the same cycle → one entry with `cmd_op`=3, `cmd_collision`=1.
- Priority: `key_evt` (0x41) and `eth_evt` (0x1234) in the same cycle → `interrupt_key` with 0x41 two edges later. On `int_ack`: 2 low cycles, then `interrupt_eth` with 0x1234.
- Drop: a second `key_evt` (0x42) while 0x41 is pending → `evt_dropped`=1 and the presented data stays 0x41. A `key_evt` (0x43) in the same cycle as the ack → 0x43 is presented after GAP.
- Reset mid-interrupt: `rst` while in KEY with 3 FIFO entries → the next cycle shows every output at 0 and the FIFO empty.

Source files
------------

// File: rtl/proc_io_pkg.sv
// Shared types for the processor I/O link: command opcodes, interrupt FSM states
// and the command FIFO entry layout.
package proc_io_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    CMD_SND = 2'd0,
    CMD_SAC = 2'd1,
    CMD_UAD = 2'd2,
    CMD_PPU = 2'd3
  } cmd_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEY  = 2'd1,
    ETH  = 2'd2,
    GAP  = 2'd3
  } irq_state_t;

  typedef struct packed {
    cmd_op_t            op;
    logic [DATA_W-1:0]  data;
  } cmd_entry_t;

  localparam int unsigned CMD_W = $bits(cmd_entry_t);

endpackage

// File: rtl/io_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module io_cmd_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head_data,
  output logic             push_drop_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign do_pop      = pop && valid;
  assign do_push     = push && (!full || do_pop);
  assign push_drop_c = push && !do_push;
  assign count_d     = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  assign head_data   = valid ? mem[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      valid   <= (count_d != '0);
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/proc_io_link.sv
// Device-side I/O endpoint: outbound command queue from processor strobes and
// inbound keyboard/Ethernet events presented as acknowledged level interrupts.
module proc_io_link
  import proc_io_pkg::*;
#(
  parameter int unsigned CMD_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snd,
  input  logic              sac,
  input  logic              uad,
  input  logic              ppu_send,
  input  logic [DATA_W-1:0] interface_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output cmd_op_t           cmd_op,
  output logic [DATA_W-1:0] cmd_data,
  output logic              cmd_overflow,
  output logic              cmd_collision,
  input  logic              key_evt,
  input  logic [DATA_W-1:0] key_code,
  input  logic              eth_evt,
  input  logic [DATA_W-1:0] eth_data,
  input  logic              int_ack,
  output logic              interrupt_key,
  output logic              interrupt_eth,
  output logic [DATA_W-1:0] interrupt_source_data,
  output logic              evt_dropped
);

  cmd_entry_t        push_entry;
  cmd_entry_t        head_entry;
  logic              cmd_push;
  logic              multi_strobe;
  logic              push_drop_c;

  logic              key_pend_q;
  logic              eth_pend_q;
  logic [DATA_W-1:0] key_data_q;
  logic [DATA_W-1:0] eth_data_q;
  logic              key_clr;
  logic              eth_clr;

  irq_state_t        state_q;
  irq_state_t        state_d;
  logic              irq_key_d;
  logic              irq_eth_d;
  logic [DATA_W-1:0] src_data_d;

  // Strobe encoder: ppu_send > snd > sac > uad
  always_comb begin
    push_entry.op   = CMD_SND;
    push_entry.data = interface_data;
    if (ppu_send)  push_entry.op = CMD_PPU;
    else if (snd)  push_entry.op = CMD_SND;
    else if (sac)  push_entry.op = CMD_SAC;
    else if (uad)  push_entry.op = CMD_UAD;
  end

  assign cmd_push     = snd | sac | uad | ppu_send;
  assign multi_strobe = ($countones({snd, sac, uad, ppu_send}) > 1);

  io_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (cmd_push),
    .push_data   (push_entry),
    .pop         (cmd_ready),
    .valid       (cmd_valid),
    .head_data   (head_entry),
    .push_drop_c (push_drop_c)
  );

  assign cmd_op   = head_entry.op;
  assign cmd_data = head_entry.data;

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_overflow  <= 1'b0;
      cmd_collision <= 1'b0;
    end else begin
      if (push_drop_c)  cmd_overflow  <= 1'b1;
      if (multi_strobe) cmd_collision <= 1'b1;
    end
  end

  assign key_clr = (state_q == KEY) && int_ack;
  assign eth_clr = (state_q == ETH) && int_ack;

  // Holding registers: a pending payload is never overwritten
  always_ff @(posedge clk) begin
    if (rst) begin
      key_pend_q  <= 1'b0;
      eth_pend_q  <= 1'b0;
      key_data_q  <= '0;
      eth_data_q  <= '0;
      evt_dropped <= 1'b0;
    end else begin
      if (key_evt) begin
        if (!key_pend_q || key_clr) begin
          key_pend_q <= 1'b1;
          key_data_q <= key_code;
        end else begin
          evt_dropped <= 1'b1;
        end
      end else if (key_clr) begin
        key_pend_q <= 1'b0;
      end
      if (eth_evt) begin
        if (!eth_pend_q || eth_clr) begin
          eth_pend_q <= 1'b1;
          eth_data_q <= eth_data;
        end else begin
          evt_dropped <= 1'b1;
        end
      end else if (eth_clr) begin
        eth_pend_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q               <= IDLE;
      interrupt_key         <= 1'b0;
      interrupt_eth         <= 1'b0;
      interrupt_source_data <= '0;
    end else begin
      state_q               <= state_d;
      interrupt_key         <= irq_key_d;
      interrupt_eth         <= irq_eth_d;
      interrupt_source_data <= src_data_d;
    end
  end

  // Outputs follow the next state so they are registered alongside it
  always_comb begin
    state_d    = state_q;
    irq_key_d  = 1'b0;
    irq_eth_d  = 1'b0;
    src_data_d = '0;
    unique case (state_q)
      IDLE: begin
        if (key_pend_q)      state_d = KEY;
        else if (eth_pend_q) state_d = ETH;
      end
      KEY:     if (int_ack) state_d = GAP;
      ETH:     if (int_ack) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    case (state_d)
      KEY: begin
        irq_key_d  = 1'b1;
        src_data_d = key_data_q;
      end
      ETH: begin
        irq_eth_d  = 1'b1;
        src_data_d = eth_data_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_io_link.sv
// Self-checking bench for proc_io_link: directed scenarios plus randomized
// traffic compared every cycle against a queue-based behavioural model.
module tb_proc_io_link;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        snd, sac, uad, ppu_send;
  logic [31:0] interface_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        cmd_overflow, cmd_collision;
  logic        key_evt, eth_evt;
  logic [31:0] key_code, eth_data;
  logic        int_ack;
  logic        interrupt_key, interrupt_eth;
  logic [31:0] interrupt_source_data;
  logic        evt_dropped;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  proc_io_link #(.CMD_DEPTH(DEPTH)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .snd                   (snd),
    .sac                   (sac),
    .uad                   (uad),
    .ppu_send              (ppu_send),
    .interface_data        (interface_data),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_op                (cmd_op),
    .cmd_data              (cmd_data),
    .cmd_overflow          (cmd_overflow),
    .cmd_collision         (cmd_collision),
    .key_evt               (key_evt),
    .key_code              (key_code),
    .eth_evt               (eth_evt),
    .eth_data              (eth_data),
    .int_ack               (int_ack),
    .interrupt_key         (interrupt_key),
    .interrupt_eth         (interrupt_eth),
    .interrupt_source_data (interrupt_source_data),
    .evt_dropped           (evt_dropped)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  bit          m_ovf, m_col, m_drop;
  bit          kp, ep;
  logic [31:0] kd, ed;
  int          m_irq;      // 0 none, 1 key, 2 eth
  int          m_cool;     // edges still forced low after an ack
  logic [31:0] m_src;

  always @(posedge clk) begin : model
    int   ns;
    bit   ck, ce;
    ent_t e;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_col = 0; m_drop = 0;
      kp = 0; ep = 0; kd = '0; ed = '0;
      m_irq = 0; m_cool = 0; m_src = '0;
    end else begin
      if (cmd_ready && q.size() > 0) void'(q.pop_front());
      ns = int'(snd) + int'(sac) + int'(uad) + int'(ppu_send);
      if (ns > 1) m_col = 1;
      if (ns > 0) begin
        e.op   = ppu_send ? 2'd3 : snd ? 2'd0 : sac ? 2'd1 : 2'd2;
        e.data = interface_data;
        if (q.size() < DEPTH) q.push_back(e);
        else m_ovf = 1;
      end
      ck = (m_irq == 1) && int_ack;
      ce = (m_irq == 2) && int_ack;
      if (m_irq != 0) begin
        if (int_ack) begin
          m_irq  = 0;
          m_cool = 1;
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (kp) begin
        m_irq = 1; m_src = kd;
      end else if (ep) begin
        m_irq = 2; m_src = ed;
      end
      if (key_evt) begin
        if (!kp || ck) begin kp = 1; kd = key_code; end
        else m_drop = 1;
      end else if (ck) kp = 0;
      if (eth_evt) begin
        if (!ep || ce) begin ep = 1; ed = eth_data; end
        else m_drop = 1;
      end else if (ce) ep = 0;
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      chk("cmd_valid", 64'(cmd_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        chk("cmd_op", 64'(cmd_op), 64'(q[0].op));
        chk("cmd_data", 64'(cmd_data), 64'(q[0].data));
      end
      chk("cmd_overflow", 64'(cmd_overflow), 64'(m_ovf));
      chk("cmd_collision", 64'(cmd_collision), 64'(m_col));
      chk("evt_dropped", 64'(evt_dropped), 64'(m_drop));
      chk("interrupt_key", 64'(interrupt_key), 64'(m_irq == 1));
      chk("interrupt_eth", 64'(interrupt_eth), 64'(m_irq == 2));
      chk("interrupt_source_data", 64'(interrupt_source_data),
          64'((m_irq != 0) ? m_src : 32'h0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    snd = 0; sac = 0; uad = 0; ppu_send = 0;
    key_evt = 0; eth_evt = 0; int_ack = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
    chk({tag, "_cmd_op"}, 64'(cmd_op), 64'd0);
    chk({tag, "_cmd_data"}, 64'(cmd_data), 64'd0);
    chk({tag, "_overflow"}, 64'(cmd_overflow), 64'd0);
    chk({tag, "_collision"}, 64'(cmd_collision), 64'd0);
    chk({tag, "_dropped"}, 64'(evt_dropped), 64'd0);
    chk({tag, "_int_key"}, 64'(interrupt_key), 64'd0);
    chk({tag, "_int_eth"}, 64'(interrupt_eth), 64'd0);
    chk({tag, "_src_data"}, 64'(interrupt_source_data), 64'd0);
  endtask

  initial begin
    rst = 1; snd = 0; sac = 0; uad = 0; ppu_send = 0;
    interface_data = '0; cmd_ready = 0;
    key_evt = 0; eth_evt = 0; key_code = '0; eth_data = '0; int_ack = 0;
    step(); step();
    rst = 0;
    chk_all_zero("reset");
    chk_en = 1'b1;

    // single command
    snd = 1; interface_data = 32'hDEADBEEF;
    step();
    chk("single_valid", 64'(cmd_valid), 64'd1);
    chk("single_op", 64'(cmd_op), 64'd0);
    chk("single_data", 64'(cmd_data), 64'hDEADBEEF);
    cmd_ready = 1;
    step();
    cmd_ready = 0;
    chk("single_popped", 64'(cmd_valid), 64'd0);

    // overflow: nine pushes into an eight-deep queue
    for (int i = 0; i < 9; i++) begin
      sac = 1; interface_data = 32'h100 + 32'(i);
      step();
    end
    chk("ovf_flag", 64'(cmd_overflow), 64'd1);
    chk("ovf_head", 64'(cmd_data), 64'h100);
    chk("ovf_op", 64'(cmd_op), 64'd1);
    sac = 1; interface_data = 32'h1FF; cmd_ready = 1;
    step();
    cmd_ready = 0;
    chk("pushpop_head", 64'(cmd_data), 64'h101);
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 64'(cmd_valid), 64'd1);
      chk("drain_data", 64'(cmd_data), (i < 7) ? 64'h101 + 64'(i) : 64'h1FF);
      cmd_ready = 1;
      step();
      cmd_ready = 0;
    end
    chk("drain_empty", 64'(cmd_valid), 64'd0);

    // collision
    ppu_send = 1; uad = 1; interface_data = 32'hC0;
    step();
    chk("coll_op", 64'(cmd_op), 64'd3);
    chk("coll_flag", 64'(cmd_collision), 64'd1);
    chk("coll_data", 64'(cmd_data), 64'hC0);
    cmd_ready = 1;
    step();
    cmd_ready = 0;
    chk("coll_single_entry", 64'(cmd_valid), 64'd0);

    // interrupt priority, drop, ack-cycle capture
    key_evt = 1; key_code = 32'h41; eth_evt = 1; eth_data = 32'h1234;
    step();
    chk("prio_not_yet", 64'(interrupt_key), 64'd0);
    step();
    chk("prio_key", 64'(interrupt_key), 64'd1);
    chk("prio_key_data", 64'(interrupt_source_data), 64'h41);
    chk("prio_no_eth", 64'(interrupt_eth), 64'd0);
    key_evt = 1; key_code = 32'h42;
    step();
    chk("drop_flag", 64'(evt_dropped), 64'd1);
    chk("drop_data_kept", 64'(interrupt_source_data), 64'h41);
    int_ack = 1; key_evt = 1; key_code = 32'h43;
    step();
    chk("gap1_key", 64'(interrupt_key), 64'd0);
    chk("gap1_data", 64'(interrupt_source_data), 64'd0);
    step();
    chk("gap2_key", 64'(interrupt_key), 64'd0);
    chk("gap2_eth", 64'(interrupt_eth), 64'd0);
    step();
    chk("ack_capture_key", 64'(interrupt_key), 64'd1);
    chk("ack_capture_data", 64'(interrupt_source_data), 64'h43);
    int_ack = 1;
    step(); step(); step();
    chk("eth_after_gap", 64'(interrupt_eth), 64'd1);
    chk("eth_data", 64'(interrupt_source_data), 64'h1234);
    int_ack = 1;
    step(); step(); step();

    // reset mid-interrupt with queued commands
    snd = 1; interface_data = 32'h1; step();
    sac = 1; interface_data = 32'h2; step();
    uad = 1; interface_data = 32'h3; step();
    key_evt = 1; key_code = 32'h77; step();
    step();
    chk("pre_rst_key", 64'(interrupt_key), 64'd1);
    chk("pre_rst_valid", 64'(cmd_valid), 64'd1);
    rst = 1;
    step();
    rst = 0;
    chk_all_zero("midrst");

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      snd            = ($urandom_range(7) == 0);
      sac            = ($urandom_range(7) == 0);
      uad            = ($urandom_range(7) == 0);
      ppu_send       = ($urandom_range(9) == 0);
      interface_data = $urandom;
      cmd_ready      = ($urandom_range(2) == 0);
      key_evt        = ($urandom_range(11) == 0);
      key_code       = $urandom;
      eth_evt        = ($urandom_range(11) == 0);
      eth_data       = $urandom;
      int_ack        = ($urandom_range(3) == 0);
      rst            = ($urandom_range(599) == 0);
      step();
    end
    rst = 0; cmd_ready = 0;
    step();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
